// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD write path.
//   - lcd_state_e : bus-controller state encoding (also used by the sequencer)
//   - RS_CMD / RS_DATA : register-select levels
//   - max3()      : elaboration helper for sizing the phase timer
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4,
        ST_DONE      = 3'd5
    } lcd_state_e;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: down-counter shared by the SETUP, STROBE and HOLD phases.
//   clk, rstn : clock, synchronous active-low reset
//   load      : reload the counter with load_val (asserted on phase entry)
//   load_val  : phase length minus one
//   expired   : counter at zero, i.e. this is the last cycle of the phase
module lcd_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/lcd_burst_wr_ctrl.sv
// lcd_burst_wr_ctrl: 8080-style LCD write-bus controller with bursts.
//   clk, rstn       : clock, synchronous active-low reset
//   start, is_cmd,
//   burst_len       : burst request, sampled only in IDLE
//   abort           : end the burst at the next beat boundary (WAIT_DATA only)
//   in_data, in_valid, in_ready : upstream beat stream
//   busy, done      : status; done pulses one cycle when a burst ends
//   LCD_CS/RS/WR/DATA : panel bus, CS and WR active low
module lcd_burst_wr_ctrl
    import lcd_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int WR_LOW_CYC = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              is_cmd,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              LCD_CS,
    output logic              LCD_RS,
    output logic              LCD_WR,
    output logic [DATA_W-1:0] LCD_DATA
);

    localparam int TMR_W = $clog2(max3(SETUP_CYC, WR_LOW_CYC, HOLD_CYC)) + 1;

    lcd_state_e       state, state_next;
    logic [LEN_W-1:0] remaining;
    logic             tmr_load, tmr_exp;
    logic [TMR_W-1:0] tmr_val;

    lcd_phase_timer #(.CNT_W(TMR_W)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Timer is reloaded on every state change, with the length of the phase
    // being entered; untimed states just get zero.
    assign tmr_load = (state_next != state);

    always_comb begin
        tmr_val = '0;
        case (state_next)
            ST_SETUP:  tmr_val = TMR_W'(SETUP_CYC - 1);
            ST_STROBE: tmr_val = TMR_W'(WR_LOW_CYC - 1);
            ST_HOLD:   tmr_val = TMR_W'(HOLD_CYC - 1);
            default:   tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:
                if (start)
                    state_next = (burst_len != '0) ? ST_WAIT_DATA : ST_DONE;
            ST_WAIT_DATA:
                if (abort)
                    state_next = ST_DONE;
                else if (in_valid)
                    state_next = ST_SETUP;
            ST_SETUP:
                if (tmr_exp) state_next = ST_STROBE;
            ST_STROBE:
                if (tmr_exp) state_next = ST_HOLD;
            ST_HOLD:
                if (tmr_exp)
                    state_next = (remaining == LEN_W'(1)) ? ST_DONE : ST_WAIT_DATA;
            ST_DONE:
                state_next = ST_IDLE;
            default:
                state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: RS latched at burst start, DATA at beat accept,
    // beat count decremented as each HOLD phase finishes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            LCD_RS    <= 1'b1;
            LCD_DATA  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE:
                    if (start && burst_len != '0) begin
                        LCD_RS    <= is_cmd ? RS_CMD : RS_DATA;
                        remaining <= burst_len;
                    end
                ST_WAIT_DATA:
                    if (!abort && in_valid)
                        LCD_DATA <= in_data;
                ST_HOLD:
                    if (tmr_exp)
                        remaining <= remaining - LEN_W'(1);
                default: ;
            endcase
        end
    end

    // Moore outputs; in_ready additionally drops while abort is high so no
    // beat is taken in the abort cycle.
    always_comb begin
        LCD_CS   = 1'b1;
        LCD_WR   = 1'b1;
        in_ready = 1'b0;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        case (state)
            ST_WAIT_DATA: begin
                LCD_CS   = 1'b0;
                in_ready = !abort;
            end
            ST_SETUP, ST_HOLD: LCD_CS = 1'b0;
            ST_STROBE: begin
                LCD_CS = 1'b0;
                LCD_WR = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_burst_wr_ctrl.sv
// tb_lcd_burst_wr_ctrl: two controller instances, default timing (0) and
// stretched timing 2/3/2 (1). Shared inputs except start; only one instance
// is exercised at a time. A pin-level monitor turns each bus into a list of
// WR pulses plus timing-rule violation counts, compared to expected beats.
module tb_lcd_burst_wr_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start[2];
    logic        is_cmd = 1'b0;
    logic [7:0]  burst_len = '0;
    logic        abort = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready[2], busy[2], done[2], cs[2], rs[2], wr[2];
    logic [15:0] dq[2];

    int SP[2] = '{1, 2};
    int LP[2] = '{1, 3};
    int HP[2] = '{1, 2};

    int n_chk = 0, n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_burst_wr_ctrl u_dut0 (
        .clk(clk), .rstn(rstn), .start(start[0]), .is_cmd(is_cmd), .burst_len(burst_len),
        .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
        .busy(busy[0]), .done(done[0]), .LCD_CS(cs[0]), .LCD_RS(rs[0]), .LCD_WR(wr[0]),
        .LCD_DATA(dq[0]));

    lcd_burst_wr_ctrl #(.SETUP_CYC(2), .WR_LOW_CYC(3), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start[1]), .is_cmd(is_cmd), .burst_len(burst_len),
        .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
        .busy(busy[1]), .done(done[1]), .LCD_CS(cs[1]), .LCD_RS(rs[1]), .LCD_WR(wr[1]),
        .LCD_DATA(dq[1]));

    // ---------------- pin monitor ----------------
    int          n_pulse[2] = '{0, 0};
    int          n_done[2]  = '{0, 0};
    int          viol[2]    = '{0, 0};
    int          fall_t[2][64];
    logic [15:0] got_d[2][64];
    logic        got_rs[2][64];
    int          rise_t[2]  = '{-100, -100};
    int          chg_t[2]   = '{0, 0};
    int          done_t[2]  = '{0, 0};
    logic [15:0] cap_d[2];
    logic        cap_rs[2];
    logic        p_wr[2]   = '{1'b1, 1'b1};
    logic [15:0] p_d[2]    = '{16'h0, 16'h0};
    logic        p_rs[2]   = '{1'b1, 1'b1};
    logic        p_busy[2] = '{1'b0, 1'b0};
    logic        p_done[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dq[i] !== p_d[i]) begin
                if (!wr[i] && !p_wr[i]) viol[i]++;                        // data moved while WR low
                if (wr[i] && (cyc - rise_t[i] < HP[i] + 1)) viol[i]++;   // hold too short
                chg_t[i] = cyc;
            end
            if (!wr[i]) begin
                if (p_wr[i]) begin
                    if (n_pulse[i] < 64) fall_t[i][n_pulse[i]] = cyc;
                    if (cyc - chg_t[i] < SP[i]) viol[i]++;               // setup too short
                end
                if (cs[i]) viol[i]++;                                    // WR low with CS high
                cap_d[i]  = dq[i];
                cap_rs[i] = rs[i];
            end else if (!p_wr[i]) begin
                if (n_pulse[i] < 64) begin
                    if (cyc - fall_t[i][n_pulse[i]] != LP[i]) viol[i]++; // strobe width
                    got_d[i][n_pulse[i]]  = cap_d[i];
                    got_rs[i][n_pulse[i]] = cap_rs[i];
                end
                rise_t[i] = cyc;
                n_pulse[i]++;
            end
            if (busy[i] && !done[i] && cs[i]) viol[i]++;                 // CS gap inside burst
            if (rs[i] !== p_rs[i] && p_busy[i] && !p_done[i]) viol[i]++; // RS moved mid-burst
            if (done[i]) begin
                if (p_done[i]) viol[i]++;                                // done longer than 1 cycle
                n_done[i]++;
                done_t[i] = cyc;
            end
            p_wr[i] = wr[i]; p_d[i] = dq[i]; p_rs[i] = rs[i];
            p_busy[i] = busy[i]; p_done[i] = done[i];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] beats[16];

    // One burst on instance idx. Expected behaviour: the first min(len,
    // abort_at) beats appear as WR pulses in order with RS = !cmd, then one done.
    task automatic burst(input int idx, input bit cmd, input int len, input int abort_at,
                         input int stall_at, input int stall_n, input bit restart);
        int  base_p, base_d, base_v, n_exp;
        bit  got, acc;
        base_p = n_pulse[idx]; base_d = n_done[idx]; base_v = viol[idx];
        n_exp  = (abort_at >= 0 && abort_at < len) ? abort_at : len;
        @(posedge clk); #1;
        start[idx] = 1'b1; is_cmd = cmd; burst_len = 8'(len);
        @(posedge clk); #1;
        start[idx] = 1'b0; is_cmd = 1'($urandom); burst_len = 8'($urandom);
        @(negedge clk);
        if (len == 0) begin
            chk("zero_len_done", 32'(done[idx]), 1);
            chk("zero_len_cs", 32'(cs[idx]), 1);
        end else begin
            chk("cs_fall", 32'(cs[idx]), 0);
        end
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                in_valid = 1'b0;
                repeat (5 + SP[idx] + LP[idx] + HP[idx]) @(posedge clk);
                #1;
                chk("ready_before_abort", 32'(in_ready[idx]), 1);
                abort = 1'b1;
                #1;
                chk("ready_in_abort", 32'(in_ready[idx]), 0);
                @(posedge clk); #1;
                abort = 1'b0;
                break;
            end
            if (k == stall_at) begin
                in_valid = 1'b0;
                repeat (stall_n) @(posedge clk);
                #1;
            end
            if (restart && k == 1) begin
                start[idx] = 1'b1; burst_len = 8'd5;
                @(posedge clk); #1;
                start[idx] = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = beats[k];
            acc = 1'b0;
            for (int w = 0; w < 200; w++) begin
                if (in_ready[idx]) begin
                    @(posedge clk); #1;
                    acc = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!acc) chk("beat_accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        if (len != 0) begin
            got = 1'b0;
            for (int w = 0; w < 300; w++) begin
                @(negedge clk);
                if (done[idx]) begin got = 1'b1; break; end
            end
            chk("done_seen", 32'(got), 1);
            chk("cs_high_with_done", 32'(cs[idx]), 1);
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done[idx]), 0);
        chk("idle_after", 32'(busy[idx]), 0);
        @(negedge clk);
        chk("done_count", 32'(n_done[idx] - base_d), 1);
        chk("pulse_count", 32'(n_pulse[idx] - base_p), 32'(n_exp));
        for (int k = 0; k < n_exp && (base_p + k) < 64; k++) begin
            chk("beat_data", 32'(got_d[idx][base_p + k]), 32'(beats[k]));
            chk("beat_rs", 32'(got_rs[idx][base_p + k]), 32'(!cmd));
        end
        if (abort_at < 0 && stall_at < 0 && !restart)
            for (int k = 0; k + 1 < n_exp && (base_p + k + 1) < 64; k++)
                chk("beat_period", 32'(fall_t[idx][base_p + k + 1] - fall_t[idx][base_p + k]),
                    32'(1 + SP[idx] + LP[idx] + HP[idx]));
        if (len > 0 && abort_at < 0)
            chk("done_after_hold", 32'(done_t[idx] - rise_t[idx]), 32'(HP[idx]));
        chk("timing_rules", 32'(viol[idx] - base_v), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int base_d;
        bit hit;
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs", 32'(cs[i]), 1);
            chk("rst_wr", 32'(wr[i]), 1);
            chk("rst_rs", 32'(rs[i]), 1);
            chk("rst_data", 32'(dq[i]), 0);
            chk("rst_ready", 32'(in_ready[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
        end
        rstn = 1'b1;

        // single command beat, default timing
        beats[0] = 16'h002C;
        burst(0, 1'b1, 1, -1, -1, 0, 1'b0);

        // three back-to-back data beats
        beats[0] = 16'h0001; beats[1] = 16'h0002; beats[2] = 16'h0003;
        burst(0, 1'b0, 3, -1, -1, 0, 1'b0);

        // stretched timing, one beat
        beats[0] = 16'($urandom);
        burst(1, 1'b0, 1, -1, -1, 0, 1'b0);

        // stall after two beats then abort: only two pulses
        for (int k = 0; k < 4; k++) beats[k] = 16'($urandom);
        burst(0, 1'b0, 4, 2, -1, 0, 1'b0);

        // zero-length burst
        burst(0, 1'b1, 0, -1, -1, 0, 1'b0);

        // start while busy is ignored
        beats[0] = 16'hA5A5; beats[1] = 16'h5A5A;
        burst(0, 1'b0, 2, -1, -1, 0, 1'b1);

        // reset while WR is low on the stretched instance
        base_d = n_done[1];
        @(posedge clk); #1;
        start[1] = 1'b1; is_cmd = 1'b0; burst_len = 8'd2;
        @(posedge clk); #1;
        start[1] = 1'b0;
        in_valid = 1'b1; in_data = 16'hBEEF;
        hit = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (!wr[1]) begin hit = 1'b1; break; end
        end
        chk("reach_strobe", 32'(hit), 1);
        rstn = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_wr", 32'(wr[1]), 1);
        chk("midrst_cs", 32'(cs[1]), 1);
        chk("midrst_busy", 32'(busy[1]), 0);
        chk("midrst_done", 32'(done[1]), 0);
        chk("midrst_data", 32'(dq[1]), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 32'(n_done[1] - base_d), 0);
        beats[0] = 16'h1234; beats[1] = 16'h4321;
        burst(1, 1'b1, 2, -1, -1, 0, 1'b0);

        // random bursts on both instances
        for (int r = 0; r < 6; r++) begin
            int len, st;
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) beats[k] = 16'($urandom);
            st = $urandom_range(0, len) - 1;
            burst(r % 2, 1'($urandom), len, -1, st, $urandom_range(1, 4), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
